iob_reg_pipe_vr: RTL and testbench
==================================

Name: iob_reg_pipe_vr

Overview:
- Parametrised pipeline of enabled registers with a valid/ready handshake at both ends.
- Carries a data word through DEPTH register stages.
- Supports per-stage backpressure and bubble collapsing: an empty stage is filled even while the output is stalled.
- Used between IOb-SoC cores where a plain enabled register cannot absorb stalls, e.g. long interconnect paths needing retiming without losing words.

Parameters:
- DATA_W, 32, width of the data word in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- RST_VAL, 0, value loaded into every data stage on reset or clear (DATA_W bits).
- LVL_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- arst_n_i  input  1  asynchronous active-low reset.
- cke_i  input  1  clock enable; when low, all state holds.
- rst_i  input  1  synchronous clear, active-high, qualified by cke_i.
- in_valid_i  input  1  upstream word valid.
- in_data_i  input  DATA_W  upstream word.
- in_ready_o  output  1  pipe accepts in_data_i this cycle.
- out_valid_o  output  1  stage DEPTH-1 holds a valid word.
- out_data_o  output  DATA_W  data of stage DEPTH-1.
- out_ready_i  input  1  downstream accepts the word this cycle.
- level_o  output  LVL_W  number of valid stages, 0..DEPTH.

Behaviour:
- Reset (arst_n_i=0): all stage valid bits are 0 and all data stages equal RST_VAL. Resulting outputs: out_valid_o=0, out_data_o=RST_VAL, level_o=0. in_ready_o=1 as soon as the reset is released.
- Synchronous clear (rst_i=1 with cke_i=1): same end state as reset at the next edge.
  - rst_i has priority over any transfer in the same cycle.
  - The word being presented is dropped, with no acceptance.
- Per stage k (0..DEPTH-1):
  - Held state: v[k] (valid bit) and d[k] (data).
  - Advance signal: adv[k] = v[k] & ready_next[k].
  - ready_next[DEPTH-1] = out_ready_i; ready_next[k] = !v[k+1] | adv[k+1].
  - Stage k loads when its upstream offers data and it can take it: load[k] = up_valid[k] & (!v[k] | adv[k]). Here up_valid[0] = in_valid_i and up_valid[k] = v[k-1].
  - On load, d[k] <= upstream data and v[k] <= 1.
  - Otherwise, if adv[k], v[k] <= 0.
  - Otherwise v[k] and d[k] hold.
  - d[k] is written only on load: the enabled-register behaviour, so no toggling on stall or bubble.
- in_ready_o = !v[0] | adv[0].
  - Combinational through the ready chain; the chain depth is DEPTH.
  - Does not depend on in_valid_i.
- Transfers:
  - Input transfer: in_valid_i & in_ready_o.
  - Output transfer: out_valid_o & out_ready_i.
- Latency and throughput: with no stalls, a word accepted at edge N appears on out_data_o after edge N+DEPTH-1, i.e. DEPTH cycles of latency. Throughput is 1 word/cycle.
- Full pipe (level_o=DEPTH) with out_ready_i=1: in_ready_o=1 and simultaneous push/pop is legal. Throughput is maintained and level_o stays at DEPTH.
- Full pipe with out_ready_i=0: in_ready_o=0 and nothing moves.
- Bubbles: invalid stages are overwritten while downstream is stalled. The pipe compacts toward the output until full.
- level_o is the registered popcount of v[]. It updates on the same edge as v[], so level_o = popcount(v).
- cke_i=0: no state change and all outputs hold. in_ready_o and out_valid_o still reflect the current state.
  - Sources must not count a transfer while cke_i=0.
  - The environment gates the handshake with cke_i.
- Reset asserted mid-transfer: the in-flight word is discarded. No output transfer is reported after reset assertion.
- Data order is strictly FIFO. No word is ever duplicated or dropped except by reset or clear.
- Inputs with X on in_data_i while in_valid_i=0 must not propagate into any valid stage.

Decomposition:
- Shared package (iob_reg_pipe_pkg): LVL_W derivation function and default constants (DATA_W=32, DEPTH=2).
- One sub-module, iob_reg_pipe_stage.
  - Contents: one valid bit and one DATA_W data register with load enable.
  - Ports: clk_i, arst_n_i, cke_i, rst_i, up_valid, up_data, down_ready, valid, data, ready.
- Top-level: a generate loop instantiating DEPTH stages, plus the level counter.

Test Plan:
- DEPTH=3, DATA_W=8: push 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready_i=1 -> out_data_o shows 0x11 three cycles after the first accept, then one word per cycle. level_o peaks at 3 and in_ready_o stays 1.
- DEPTH=3: out_ready_i=0, push 0xA1,0xA2,0xA3,0xA4 -> first three are accepted and level_o=3. in_ready_o=0 while 0xA4 is held. Raise out_ready_i -> output order A1,A2,A3,A4 and level_o never exceeds 3.
- DEPTH=3, bubble: push 0x01, idle 2 cycles, push 0x02, out_ready_i=0 -> both compact into stages 2 and 1, level_o=2, in_ready_o=1.
- Full pipe, in_valid_i=1 and out_ready_i=1 for 5 cycles -> 5 pops and 5 pushes, level_o constant at 3, no data loss.
- arst_n_i low for 1 cycle while level_o=2 -> out_valid_o=0, out_data_o=RST_VAL, level_o=0 immediately. After release, in_ready_o=1. Repeat the same check with rst_i=1 and in_valid_i=1 -> word not accepted.
- cke_i=0 for 4 cycles mid-stream with toggling out_ready_i -> no state change and level_o held. Stream resumes in order after cke_i=1.

Source files
------------

// File: rtl/iob_reg_pipe_pkg.sv
// Shared defaults and width helper for the valid/ready register pipe.
package iob_reg_pipe_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 2;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/iob_reg_pipe_stage.sv
// One pipe stage: a valid bit plus a data register loaded only on acceptance.
module iob_reg_pipe_stage
  import iob_reg_pipe_pkg::*;
#(
  parameter int unsigned           DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0]     RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  input  logic              down_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              ready
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              adv, load;

  always_comb begin
    adv     = valid_q & down_ready;
    ready   = ~valid_q | adv;
    load    = up_valid & ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (rst_i) begin
      valid_d = 1'b0;
      data_d  = RST_VAL;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = up_data;
    end else if (adv) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else if (cke_i) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/iob_reg_pipe_vr.sv
// DEPTH-stage register pipe with valid/ready at both ends and bubble collapsing.
module iob_reg_pipe_vr
  import iob_reg_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = DEF_DATA_W,
  parameter int unsigned       DEPTH   = DEF_DEPTH,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int unsigned       LVL_W   = lvl_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [LVL_W-1:0]  level_o
);

  // Element k is what feeds stage k; element DEPTH is the pipe output side.
  logic              vch [DEPTH+1];
  logic [DATA_W-1:0] dch [DEPTH+1];
  logic              rdy [DEPTH+1];

  assign vch[0]     = in_valid_i;
  assign dch[0]     = in_data_i;
  assign rdy[DEPTH] = out_ready_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    iob_reg_pipe_stage #(
      .DATA_W (DATA_W),
      .RST_VAL(RST_VAL)
    ) u_stage (
      .clk_i     (clk_i),
      .arst_n_i  (arst_n_i),
      .cke_i     (cke_i),
      .rst_i     (rst_i),
      .up_valid  (vch[k]),
      .up_data   (dch[k]),
      .down_ready(rdy[k+1]),
      .valid     (vch[k+1]),
      .data      (dch[k+1]),
      .ready     (rdy[k])
    );
  end

  assign in_ready_o  = rdy[0];
  assign out_valid_o = vch[DEPTH];
  assign out_data_o  = dch[DEPTH];

  // Tracking pushes minus pops keeps the count equal to popcount of the valid bits.
  logic             in_xfer, out_xfer;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    in_xfer  = in_valid_i & rdy[0];
    out_xfer = vch[DEPTH] & out_ready_i;
    level_d  = level_q;
    if (rst_i)
      level_d = '0;
    else if (in_xfer && !out_xfer)
      level_d = level_q + LVL_W'(1);
    else if (!in_xfer && out_xfer)
      level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)
      level_q <= '0;
    else if (cke_i)
      level_q <= level_d;
  end

  assign level_o = level_q;

endmodule

// File: tb/tb_iob_reg_pipe_vr.sv
// Scoreboard bench for iob_reg_pipe_vr with DEPTH=3, DATA_W=8.
module tb_iob_reg_pipe_vr;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 3;
  localparam logic [DW-1:0] RV = 8'h5A;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          cke = 1'b1;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [1:0]    level;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [DW-1:0] sb [$];

  iob_reg_pipe_vr #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .RST_VAL(RV)
  ) dut (
    .clk_i      (clk),
    .arst_n_i   (arst_n),
    .cke_i      (cke),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready),
    .level_o    (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples mid-cycle, before the edge that would perform the transfers.
  always @(negedge clk) begin
    if (arst_n) begin
      chk("level_vs_sb", 32'(level), 32'(sb.size()));
      if (cke && rst) begin
        sb.delete();
      end else if (cke) begin
        if (out_valid && out_ready) begin
          pops++;
          if (sb.size() == 0) begin
            chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            chk("out_data", 32'(out_data), 32'(sb.pop_front()));
          end
        end
        if (in_valid && in_ready) sb.push_back(in_data);
      end
    end
  end

  task automatic push(input logic [DW-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && level != 0; i++) tick();
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_sb", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    #2 arst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'(RV));
    chk("rst_level", 32'(level), 32'd0);
    tick();
    arst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming with no stall: latency of three edges, one word per cycle.
    out_ready = 1'b1;
    push(8'h11); chk("t1_level1", 32'(level), 32'd1); chk("t1_rdy1", 32'(in_ready), 32'd1);
    push(8'h22); chk("t1_level2", 32'(level), 32'd2); chk("t1_ov2", 32'(out_valid), 32'd0);
    push(8'h33); chk("t1_ov3", 32'(out_valid), 32'd1); chk("t1_od3", 32'(out_data), 32'h11);
    chk("t1_level3", 32'(level), 32'd3); chk("t1_rdy3", 32'(in_ready), 32'd1);
    push(8'h44); chk("t1_level4", 32'(level), 32'd3); chk("t1_od4", 32'(out_data), 32'h22);
    drain();

    // Stalled output fills the pipe, then drains in order.
    out_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3);
    in_data = 8'hA4;
    #1;
    chk("t2_level_full", 32'(level), 32'd3);
    chk("t2_rdy_full", 32'(in_ready), 32'd0);
    tick();
    chk("t2_level_hold", 32'(level), 32'd3);
    chk("t2_od_hold", 32'(out_data), 32'hA1);
    out_ready = 1'b1;
    #1;
    chk("t2_rdy_pop", 32'(in_ready), 32'd1);
    tick();
    chk("t2_level_pushpop", 32'(level), 32'd3);
    drain();

    // Bubble compaction while stalled.
    out_ready = 1'b0;
    push(8'h01);
    idle(); tick(); tick();
    push(8'h02);
    idle(); tick();
    chk("t3_level", 32'(level), 32'd2);
    chk("t3_rdy", 32'(in_ready), 32'd1);
    chk("t3_ov", 32'(out_valid), 32'd1);
    chk("t3_od", 32'(out_data), 32'h01);

    // Full pipe with simultaneous push and pop for five cycles.
    push(8'h03);
    chk("t4_level_full", 32'(level), 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(8'(4 + i));
      chk("t4_level_const", 32'(level), 32'd3);
      chk("t4_rdy", 32'(in_ready), 32'd1);
    end
    idle(); tick();
    chk("t4_level_after", 32'(level), 32'd2);

    // Asynchronous reset with words in flight.
    out_ready = 1'b0;
    arst_n = 1'b0;
    sb.delete();
    #1;
    chk("t5_ar_ov", 32'(out_valid), 32'd0);
    chk("t5_ar_od", 32'(out_data), 32'(RV));
    chk("t5_ar_level", 32'(level), 32'd0);
    tick();
    arst_n = 1'b1;
    #1;
    chk("t5_ar_rdy", 32'(in_ready), 32'd1);

    // Synchronous clear beats a concurrent push.
    push(8'hB1); push(8'hB2);
    chk("t5_sc_pre", 32'(level), 32'd2);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hB3;
    tick();
    chk("t5_sc_level", 32'(level), 32'd0);
    chk("t5_sc_ov", 32'(out_valid), 32'd0);
    chk("t5_sc_od", 32'(out_data), 32'(RV));
    rst = 1'b0;
    idle(); tick();
    chk("t5_sc_noaccept", 32'(level), 32'd0);

    // Clock enable low freezes everything despite toggling out_ready.
    push(8'hC1); push(8'hC2);
    idle(); tick();
    chk("t6_pre_od", 32'(out_data), 32'hC1);
    cke = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      out_ready = ~out_ready;
      tick();
      chk("t6_level_hold", 32'(level), 32'd2);
      chk("t6_od_hold", 32'(out_data), 32'hC1);
      chk("t6_ov_hold", 32'(out_valid), 32'd1);
    end
    cke = 1'b1;
    out_ready = 1'b1;
    push(8'hC3); push(8'hC4);
    drain();

    // 4 + 4 + 6 (01..06) + 4 popped words; 07, 08 discarded by reset.
    chk("total_pops", 32'(pops), 32'd18);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
